// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: loads a WIDTH-bit pattern and steps it (shl/shr/rol/bounce)
// once every TICK_DIV clocks, stopping after STEPS steps (0 = free-running).
module led_pattern_sequencer #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 4,
  parameter int STEPS    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [1:0]       load_mode,
  input  logic             stop,
  output logic [WIDTH-1:0] led,
  output logic             busy,
  output logic             done,
  output logic [7:0]       step_cnt,
  output logic [1:0]       dbg_state
);

  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]     STEPS_LAST = 8'(STEPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pat, w_pat_nxt, w_shift_pat;
  logic [1:0]       r_mode, w_mode_nxt;
  logic             r_dir, w_dir_nxt, w_shift_dir;   // 0 = moving left, 1 = moving right
  logic [PW-1:0]    r_presc, w_presc_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_done, w_done_nxt;
  logic             w_load, w_step_en, w_last;

  // Load handshake: a transfer happens on any posedge where load_valid and
  // load_ready are both high; load_ready is high outside RUN, and a load_valid
  // seen while load_ready is low is dropped (nothing is buffered).
  assign w_load    = load_valid & load_ready;
  assign w_step_en = (r_state == S_RUN) && (r_presc == PRESC_LAST);
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_last    = (STEPS != 0) && (w_cnt_inc == STEPS_LAST);

  always_comb begin
    w_shift_pat = r_pat;
    w_shift_dir = r_dir;
    case (r_mode)
      2'b00: w_shift_pat = r_pat << 1;
      2'b01: w_shift_pat = r_pat >> 1;
      2'b10: w_shift_pat = {r_pat[WIDTH-2:0], r_pat[WIDTH-1]};
      default: begin
        // Bounce reverses when the lit edge bit would fall off the end.
        if (!r_dir && r_pat[WIDTH-1]) begin
          w_shift_dir = 1'b1;
          w_shift_pat = r_pat >> 1;
        end else if (r_dir && r_pat[0]) begin
          w_shift_dir = 1'b0;
          w_shift_pat = r_pat << 1;
        end else if (r_dir) begin
          w_shift_pat = r_pat >> 1;
        end else begin
          w_shift_pat = r_pat << 1;
        end
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_mode_nxt  = r_mode;
    w_dir_nxt   = r_dir;
    w_presc_nxt = r_presc;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_load) begin
          w_state_nxt = S_RUN;
          w_pat_nxt   = load_data;
          w_mode_nxt  = load_mode;
          w_dir_nxt   = 1'b0;
          w_presc_nxt = '0;
          w_cnt_nxt   = 8'd0;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_presc_nxt = '0;
        end else if (w_step_en) begin
          w_presc_nxt = '0;
          w_pat_nxt   = w_shift_pat;
          w_dir_nxt   = w_shift_dir;
          w_cnt_nxt   = w_cnt_inc;
          if (w_last) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_mode  <= 2'b00;
      r_dir   <= 1'b0;
      r_presc <= '0;
      r_cnt   <= 8'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_mode  <= w_mode_nxt;
      r_dir   <= w_dir_nxt;
      r_presc <= w_presc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign load_ready = (r_state != S_RUN);
  assign busy       = (r_state == S_RUN);
  assign led        = r_pat;
  assign done       = r_done;
  assign step_cnt   = r_cnt;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: vector table, hand-written corner sequences,
// and randomized traffic checked against a step-rule reference model.
module tb_led_pattern_sequencer;

  localparam int W  = 8;
  localparam int TD = 4;
  localparam int ST = 4;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         a_lv, a_rdy, a_stop, a_busy, a_done;
  logic [W-1:0] a_data, a_led;
  logic [1:0]   a_mode, a_dbg;
  logic [7:0]   a_cnt;

  logic         b_lv, b_rdy, b_stop, b_busy, b_done;
  logic [W-1:0] b_data, b_led;
  logic [1:0]   b_mode, b_dbg;
  logic [7:0]   b_cnt;

  led_pattern_sequencer #(.WIDTH(W), .TICK_DIV(TD), .STEPS(ST)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_valid(a_lv), .load_ready(a_rdy),
    .load_data(a_data), .load_mode(a_mode), .stop(a_stop), .led(a_led),
    .busy(a_busy), .done(a_done), .step_cnt(a_cnt), .dbg_state(a_dbg)
  );

  led_pattern_sequencer #(.WIDTH(W), .TICK_DIV(1), .STEPS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_valid(b_lv), .load_ready(b_rdy),
    .load_data(b_data), .load_mode(b_mode), .stop(b_stop), .led(b_led),
    .busy(b_busy), .done(b_done), .step_cnt(b_cnt), .dbg_state(b_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // reference model for dut_a: step rules applied to a whole pattern value
  function automatic logic [W:0] model_step(input logic [W-1:0] p, input logic [1:0] md, input bit dr);
    case (md)
      2'd0: return {dr, p << 1};
      2'd1: return {dr, p >> 1};
      2'd2: return {dr, (p << 1) | (p >> (W - 1))};
      default: begin
        if (p == '0)           return {dr, p};
        if (!dr && p[W-1])     return {1'b1, p >> 1};
        if (dr && p[0])        return {1'b0, p << 1};
        if (dr)                return {dr, p >> 1};
        return {dr, p << 1};
      end
    endcase
  endfunction

  logic [W-1:0] m_pat;
  logic [1:0]   m_mode;
  bit           m_run, m_dir_r, m_done;
  int           m_since, m_steps;

  always @(posedge clk or negedge rst_n) begin : ref_model
    logic [W-1:0] p;
    logic [1:0]   md;
    bit           run, dr, dn;
    int           since, steps;
    logic [W:0]   nx;
    if (!rst_n) begin
      m_pat <= '0; m_mode <= 2'b00; m_run <= 1'b0; m_dir_r <= 1'b0;
      m_done <= 1'b0; m_since <= 0; m_steps <= 0;
    end else begin
      p = m_pat; md = m_mode; run = m_run; dr = m_dir_r;
      since = m_since; steps = m_steps; dn = 1'b0;
      if (!run) begin
        if (a_lv) begin
          p = a_data; md = a_mode; dr = 1'b0; since = 0; steps = 0; run = 1'b1;
        end
      end else if (a_stop) begin
        run = 1'b0;
      end else begin
        since++;
        if (since % TD == 0) begin
          nx = model_step(p, md, dr);
          dr = nx[W];
          p  = nx[W-1:0];
          if (steps < 255) steps++;
          if (ST != 0 && steps == ST) begin
            run = 1'b0;
            dn  = 1'b1;
          end
        end
      end
      m_pat <= p; m_mode <= md; m_run <= run; m_dir_r <= dr;
      m_done <= dn; m_since <= since; m_steps <= steps;
    end
  end

  typedef struct {
    logic [W-1:0]       data;
    logic [1:0]         mode;
    logic [0:3][W-1:0]  exp;
  } vec_t;

  vec_t vecs[4];

  // driver / stimulus
  initial begin
    logic [W-1:0] one;
    logic [W-1:0] exp_led;

    vecs[0] = '{8'b00101101, 2'b00, {8'b01011010, 8'b10110100, 8'b01101000, 8'b11010000}};
    vecs[1] = '{8'b10110110, 2'b01, {8'b01011011, 8'b00101101, 8'b00010110, 8'b00001011}};
    vecs[2] = '{8'b10000001, 2'b10, {8'b00000011, 8'b00000110, 8'b00001100, 8'b00011000}};
    vecs[3] = '{8'b01000000, 2'b11, {8'b10000000, 8'b01000000, 8'b00100000, 8'b00010000}};

    a_lv = 0; a_data = '0; a_mode = 0; a_stop = 0;
    b_lv = 0; b_data = '0; b_mode = 0; b_stop = 0;

    repeat (2) @(negedge clk);
    check8("rst_led", a_led, 8'd0);
    check8("rst_cnt", a_cnt, 8'd0);
    check1("rst_busy", a_busy, 1'b0);
    check1("rst_ready", a_rdy, 1'b1);
    check1("rst_done", a_done, 1'b0);
    check1("rst_b_ready", b_rdy, 1'b1);
    rst_n = 1'b1;

    // table-driven runs: each step lands TICK_DIV edges after the previous one
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      a_lv = 1; a_data = vecs[v].data; a_mode = vecs[v].mode;
      @(negedge clk);
      a_lv = 0;
      check1("vec_busy", a_busy, 1'b1);
      check1("vec_ready", a_rdy, 1'b0);
      check8("vec_load", a_led, vecs[v].data);
      for (int s = 0; s < 4; s++) begin
        repeat (TD - 1) @(posedge clk);
        @(negedge clk);
        check8("vec_hold", a_led, (s == 0) ? vecs[v].data : vecs[v].exp[s-1]);
        @(posedge clk);
        @(negedge clk);
        check8("vec_step", a_led, vecs[v].exp[s]);
        check1("vec_done_early", a_done, (s == 3));
      end
      check8("vec_cnt", a_cnt, 8'd4);
      check1("vec_end_busy", a_busy, 1'b0);
      check1("vec_end_ready", a_rdy, 1'b1);
      @(negedge clk);
      check1("vec_done_pulse", a_done, 1'b0);
      check8("vec_done_hold", a_led, vecs[v].exp[3]);
    end

    // load_valid during RUN is dropped; then stop mid-run holds pattern and count
    a_lv = 1; a_data = 8'b00000001; a_mode = 2'b00;
    @(negedge clk);
    a_data = 8'hFF; a_mode = 2'b01;
    repeat (TD) @(posedge clk);
    @(negedge clk);
    a_lv = 0;
    check8("ignored_load", a_led, 8'b00000010);
    a_stop = 1;
    @(negedge clk);
    a_stop = 0;
    check1("stop_busy", a_busy, 1'b0);
    check1("stop_ready", a_rdy, 1'b1);
    check1("stop_done", a_done, 1'b0);
    check8("stop_led", a_led, 8'b00000010);
    check8("stop_cnt", a_cnt, 8'd1);

    // stop on the same edge as a step: no shift
    a_lv = 1; a_data = 8'b00110000; a_mode = 2'b10;
    @(negedge clk);
    a_lv = 0;
    repeat (TD - 1) @(posedge clk);
    @(negedge clk);
    a_stop = 1;
    @(negedge clk);
    a_stop = 0;
    check8("stop_vs_step_led", a_led, 8'b00110000);
    check8("stop_vs_step_cnt", a_cnt, 8'd0);
    check1("stop_vs_step_busy", a_busy, 1'b0);

    // asynchronous reset between clock edges
    a_lv = 1; a_data = 8'hA5; a_mode = 2'b10;
    @(negedge clk);
    a_lv = 0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check8("arst_led", a_led, 8'd0);
    check8("arst_cnt", a_cnt, 8'd0);
    check1("arst_busy", a_busy, 1'b0);
    check1("arst_ready", a_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // free-running rotate with TICK_DIV=1: step every edge, count saturates
    @(negedge clk);
    b_lv = 1; b_data = 8'b00000001; b_mode = 2'b10;
    @(negedge clk);
    b_lv = 0;
    check8("b_load", b_led, 8'b00000001);
    check1("b_busy0", b_busy, 1'b1);
    one = 8'b00000001;
    for (int i = 1; i <= 308; i++) begin
      @(negedge clk);
      exp_led = one << (i % 8);
      check8("b_rol", b_led, exp_led);
      check1("b_no_done", b_done, 1'b0);
    end
    check8("b_cnt_sat", b_cnt, 8'd255);
    check1("b_busy", b_busy, 1'b1);
    b_stop = 1;
    @(negedge clk);
    b_stop = 0;
    check1("b_stop_busy", b_busy, 1'b0);
    check1("b_stop_ready", b_rdy, 1'b1);
    check8("b_stop_led", b_led, 8'b00010000);
    check8("b_stop_cnt", b_cnt, 8'd255);

    // randomized traffic on dut_a against the reference model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      check8("rnd_led", a_led, m_pat);
      check8("rnd_cnt", a_cnt, 8'(m_steps));
      check1("rnd_busy", a_busy, m_run);
      check1("rnd_ready", a_rdy, !m_run);
      check1("rnd_done", a_done, m_done);
      if (c % 700 == 350) begin
        #2 rst_n = 1'b0;
        #1;
        check8("rnd_arst_led", a_led, 8'd0);
        check1("rnd_arst_ready", a_rdy, 1'b1);
        #1 rst_n = 1'b1;
      end
      a_lv   = ($urandom_range(0, 2) == 0);
      a_data = W'($urandom);
      a_mode = 2'($urandom_range(0, 3));
      a_stop = ($urandom_range(0, 19) == 0);
    end
    a_lv = 0; a_stop = 0;

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
